// File: rtl/uart_sched_pkg.sv
// Shared types and default parameters for the UART transmit scheduler.
package uart_sched_pkg;

  localparam int DEF_NUM_REQ        = 4;
  localparam int DEF_MAX_MSG_LEN    = 64;
  localparam int DEF_ACCEPT_TIMEOUT = 4;

  // ARB: looking for a requester; SEND: grant held, waiting for a byte and an
  // idle transmitter; WAIT_ACCEPT: start pulse issued, waiting for tx_ready to
  // fall; WAIT_DONE: frame on the line, waiting for tx_ready to return.
  typedef enum logic [1:0] {
    ARB         = 2'd0,
    SEND        = 2'd1,
    WAIT_ACCEPT = 2'd2,
    WAIT_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin select: the first set bit of req searching upward
// from (last_grant + 1) mod NUM_REQ, wrapping around. The last winner is
// therefore always the lowest priority.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_grant,
  output logic               any,
  output logic [IW-1:0]      idx
);

  logic [IW-1:0] cand;

  // Walk the candidates in priority order and keep the first requester found.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IW'((int'(last_grant) + i) % NUM_REQ);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between NUM_REQ byte-stream requesters. The
// grant is taken round-robin and held for a whole message (or MAX_MSG_LEN
// bytes), so messages never interleave on the line.
//
// Handshakes: a byte moves from requester i when req_valid[i] && req_ready[i]
// are both high at a rising clk edge; req_ready[i] is asserted only for the
// granted requester, only in SEND, and only while tx_ready is high, and
// req_valid/req_data/req_last must be held until that edge. The transmitter
// side is a one-cycle tx_send pulse with tx_data held until tx_ready returns.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter  int NUM_REQ        = DEF_NUM_REQ,
  parameter  int MAX_MSG_LEN    = DEF_MAX_MSG_LEN,
  parameter  int ACCEPT_TIMEOUT = DEF_ACCEPT_TIMEOUT,
  localparam int IW             = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_send,
  output logic [7:0]           tx_data,
  input  logic                 tx_ready,
  output logic [IW-1:0]        grant_id,
  output logic                 busy,
  output logic                 err_accept,
  output logic                 err_trunc,
  output logic [1:0]           state_dbg
);

  localparam int AW = $clog2(ACCEPT_TIMEOUT + 1);

  state_t        state;
  state_t        state_next;
  logic [IW-1:0] g;
  logic [IW-1:0] last_grant;
  logic [7:0]    byte_cnt;
  logic          last_q;
  logic [AW-1:0] acc_cnt;

  logic          arb_any;
  logic [IW-1:0] arb_idx;
  logic          grant_load;
  logic          byte_take;
  logic          release_grant;
  logic          accept_fail;
  logic          trunc;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .any        (arb_any),
    .idx        (arb_idx)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ARB;
    else          state <= state_next;
  end

  // Next-state logic, the combinational req_ready and datapath strobes.
  always_comb begin
    state_next    = state;
    req_ready     = '0;
    grant_load    = 1'b0;
    byte_take     = 1'b0;
    release_grant = 1'b0;
    accept_fail   = 1'b0;
    trunc         = 1'b0;
    case (state)
      ARB: begin
        if (arb_any) begin
          grant_load = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (tx_ready && req_valid[g]) begin
          req_ready[g] = 1'b1;
          byte_take    = 1'b1;
          state_next   = WAIT_ACCEPT;
        end
      end
      WAIT_ACCEPT: begin
        if (!tx_ready) begin
          state_next = WAIT_DONE;
        end else if (acc_cnt == AW'(ACCEPT_TIMEOUT - 1)) begin
          // Transmitter never went busy: give up on this message.
          accept_fail   = 1'b1;
          release_grant = 1'b1;
          state_next    = ARB;
        end
      end
      WAIT_DONE: begin
        if (tx_ready) begin
          if (last_q || byte_cnt == 8'(MAX_MSG_LEN)) begin
            release_grant = 1'b1;
            trunc         = !last_q;
            state_next    = ARB;
          end else begin
            state_next = SEND;
          end
        end
      end
      default: state_next = ARB;
    endcase
  end

  // Grant, byte capture, accept-timeout counter and sticky error flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      g          <= '0;
      last_grant <= IW'(NUM_REQ - 1);
      byte_cnt   <= '0;
      last_q     <= 1'b0;
      acc_cnt    <= '0;
      tx_send    <= 1'b0;
      tx_data    <= '0;
      err_accept <= 1'b0;
      err_trunc  <= 1'b0;
    end else begin
      tx_send <= byte_take;
      if (grant_load) begin
        g        <= arb_idx;
        byte_cnt <= '0;
      end
      if (byte_take) begin
        tx_data  <= req_data[{g, 3'b000} +: 8];
        last_q   <= req_last[g];
        byte_cnt <= byte_cnt + 8'd1;
        acc_cnt  <= '0;
      end else if (state == WAIT_ACCEPT && tx_ready) begin
        acc_cnt <= acc_cnt + 1'b1;
      end
      if (release_grant) last_grant <= g;
      if (accept_fail)   err_accept <= 1'b1;
      if (trunc)         err_trunc  <= 1'b1;
    end
  end

  assign grant_id  = g;
  assign busy      = (state != ARB);
  assign state_dbg = state;

endmodule
